// File: rtl/seq_cmd_pkg.sv
// seq_cmd_pkg: op codes, FSM state encoding and symbol validity check for seq_cmd_decoder
package seq_cmd_pkg;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_SET    = 2'b11;

    typedef enum logic [1:0] {IDLE, ARMED, FIRE} state_t;

    // A nonzero op already implies a nonzero symbol, so only op and range matter
    function automatic logic sym_valid(input logic [1:0] op, input logic [31:0] ch, input int unsigned channels);
        return op != 2'b00 && ch < channels;
    endfunction
endpackage

// File: rtl/seq_cmd_outbank.sv
// seq_cmd_outbank: channel output register bank applying set/clear/toggle to one addressed bit
module seq_cmd_outbank
    import seq_cmd_pkg::*;
#(
    parameter int CH_BITS = 2,
    parameter int CHANNELS = 4,
    parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                apply_i,
    input  logic [CH_BITS-1:0]  ch_i,
    input  logic [1:0]          op_i,
    output logic [CHANNELS-1:0] yout_o
);
    logic [CHANNELS-1:0] bank_q, bank_d, sel;

    assign sel = apply_i ? CHANNELS'(1) << ch_i : '0;

    always_comb
        bank_d = op_i == OP_SET ? bank_q | sel : op_i == OP_CLEAR ? bank_q & ~sel : op_i == OP_TOGGLE ? bank_q ^ sel : bank_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) bank_q <= RESET_VAL;
        else bank_q <= bank_d;

    assign yout_o = bank_q;
endmodule

// File: rtl/seq_cmd_decoder.sv
// seq_cmd_decoder: serial command decoder; a command followed by IDLE_LEN zero symbols executes on one channel
module seq_cmd_decoder
    import seq_cmd_pkg::*;
#(
    parameter int CH_BITS = 2,
    parameter int CHANNELS = 4,
    parameter int IDLE_LEN = 2,
    parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CH_BITS+1:0]  ain,
    output logic [CHANNELS-1:0] yout,
    output logic                exec_valid,
    output logic [CH_BITS-1:0]  exec_ch,
    output logic [1:0]          exec_op,
    output logic                busy
);
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d, exec_op_q;
    logic [CH_BITS-1:0] ch_q, ch_d, exec_ch_q;
    logic exec_valid_q, busy_q, valid, apply;

    assign valid = sym_valid(ain[1:0], 32'(ain[CH_BITS+1:2]), CHANNELS);
    assign apply = state_q == FIRE;

    // FIRE shares the IDLE decode so a command arriving in the execute cycle is not lost
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        op_d = op_q;
        ch_d = ch_q;
        if (state_q == ARMED && ain == '0) begin
            state_d = cnt_q == 8'(IDLE_LEN - 1) ? FIRE : ARMED;
            cnt_d = cnt_q == 8'(IDLE_LEN - 1) ? cnt_q : cnt_q + 8'd1;
        end else if (valid) begin
            state_d = ARMED;
            cnt_d = '0;
            op_d = ain[1:0];
            ch_d = ain[CH_BITS+1:2];
        end else if (ain != '0 || state_q == FIRE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            op_q <= '0;
            ch_q <= '0;
            exec_valid_q <= 1'b0;
            exec_ch_q <= '0;
            exec_op_q <= '0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            op_q <= op_d;
            ch_q <= ch_d;
            exec_valid_q <= apply;
            exec_ch_q <= apply ? ch_q : exec_ch_q;
            exec_op_q <= apply ? op_q : exec_op_q;
            busy_q <= state_d != IDLE;
        end

    seq_cmd_outbank #(.CH_BITS(CH_BITS), .CHANNELS(CHANNELS), .RESET_VAL(RESET_VAL)) u_bank (
        .clk(clk),
        .reset(reset),
        .apply_i(apply),
        .ch_i(ch_q),
        .op_i(op_q),
        .yout_o(yout)
    );

    assign exec_valid = exec_valid_q;
    assign exec_ch = exec_ch_q;
    assign exec_op = exec_op_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_seq_cmd_decoder.sv
// tb_seq_cmd_decoder: directed table plus corner sequences over default, CHANNELS=3 and IDLE_LEN=5 builds
module tb_seq_cmd_decoder;
    logic clk = 1'b0, reset = 1'b1;
    logic [3:0] ain = '0;
    logic [3:0] y0, y5;
    logic [2:0] y3;
    logic ev0, ev3, ev5, b0, b3, b5;
    logic [1:0] c0, c3, c5, o0, o3, o5;
    int errors = 0, checks = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] y;
        logic ev;
        logic [1:0] ch;
        logic [1:0] op;
        logic busy;
    } vec_t;
    vec_t tbl [34];

    always #5 clk = ~clk;

    seq_cmd_decoder d0 (.clk(clk), .reset(reset), .ain(ain), .yout(y0), .exec_valid(ev0), .exec_ch(c0), .exec_op(o0), .busy(b0));
    seq_cmd_decoder #(.CHANNELS(3)) d3 (.clk(clk), .reset(reset), .ain(ain), .yout(y3), .exec_valid(ev3), .exec_ch(c3), .exec_op(o3), .busy(b3));
    seq_cmd_decoder #(.IDLE_LEN(5)) d5 (.clk(clk), .reset(reset), .ain(ain), .yout(y5), .exec_valid(ev5), .exec_ch(c5), .exec_op(o5), .busy(b5));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] a);
        @(negedge clk) ain = a;
        @(posedge clk) #1;
    endtask

    task automatic rst_pulse();
        @(negedge clk) begin
            reset = 1'b1;
            ain = '0;
        end
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        tbl = '{
            '{4'b1011, 4'b0000, 0, 0, 0, 1}, '{4'b0000, 4'b0000, 0, 0, 0, 1},
            '{4'b0000, 4'b0000, 0, 0, 0, 1}, '{4'b0000, 4'b0100, 1, 2, 3, 0},
            '{4'b0000, 4'b0100, 0, 2, 3, 0},
            '{4'b0010, 4'b0100, 0, 2, 3, 1}, '{4'b0000, 4'b0100, 0, 2, 3, 1},
            '{4'b0000, 4'b0100, 0, 2, 3, 1}, '{4'b0000, 4'b0101, 1, 0, 2, 0},
            '{4'b0010, 4'b0101, 0, 0, 2, 1}, '{4'b0000, 4'b0101, 0, 0, 2, 1},
            '{4'b0000, 4'b0101, 0, 0, 2, 1}, '{4'b1001, 4'b0100, 1, 0, 2, 1},
            '{4'b0000, 4'b0100, 0, 0, 2, 1}, '{4'b0000, 4'b0100, 0, 0, 2, 1},
            '{4'b0000, 4'b0000, 1, 2, 1, 0},
            '{4'b1011, 4'b0000, 0, 2, 1, 1}, '{4'b0000, 4'b0000, 0, 2, 1, 1},
            '{4'b0111, 4'b0000, 0, 2, 1, 1}, '{4'b0000, 4'b0000, 0, 2, 1, 1},
            '{4'b0000, 4'b0000, 0, 2, 1, 1}, '{4'b0000, 4'b0010, 1, 1, 3, 0},
            '{4'b0111, 4'b0010, 0, 1, 3, 1}, '{4'b0000, 4'b0010, 0, 1, 3, 1},
            '{4'b0000, 4'b0010, 0, 1, 3, 1}, '{4'b0000, 4'b0010, 1, 1, 3, 0},
            '{4'b1000, 4'b0010, 0, 1, 3, 0}, '{4'b0000, 4'b0010, 0, 1, 3, 0},
            '{4'b1011, 4'b0010, 0, 1, 3, 1}, '{4'b0000, 4'b0010, 0, 1, 3, 1},
            '{4'b0100, 4'b0010, 0, 1, 3, 0}, '{4'b0000, 4'b0010, 0, 1, 3, 0},
            '{4'b0000, 4'b0010, 0, 1, 3, 0}, '{4'b0000, 4'b0010, 0, 1, 3, 0}
        };
        #12;
        chk("reset_d0", {y0, ev0, c0, o0, b0}, 16'h0);
        chk("reset_d3", {y3, ev3, c3, o3, b3}, 16'h0);
        chk("reset_d5", {y5, ev5, c5, o5, b5}, 16'h0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 34; i++) begin
            step(tbl[i].a);
            chk($sformatf("vec%0d", i), {y0, ev0, c0, o0, b0}, {tbl[i].y, tbl[i].ev, tbl[i].ch, tbl[i].op, tbl[i].busy});
        end

        // Asynchronous reset mid-gap: takes effect without a clock edge
        step(4'b1011);
        step(4'b0000);
        #2 reset = 1'b1;
        #1 chk("async_rst", {y0, ev0, c0, o0, b0}, 16'h0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(4'b0000);
            chk($sformatf("post_rst%0d", i), {y0, ev0, b0}, 16'h0);
        end

        rst_pulse();
        step(4'b1111);
        chk("ch3_range_busy", b3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000);
            chk($sformatf("ch3_range_gap%0d", i), {y3, ev3}, 16'h0);
        end
        step(4'b1000);
        chk("ch3_op00_busy", b3, 1'b0);
        step(4'b0111);
        step(4'b0000);
        step(4'b0000);
        step(4'b0000);
        chk("ch3_set1", {y3, ev3, c3, o3}, {3'b010, 1'b1, 2'd1, 2'd3});

        rst_pulse();
        step(4'b1011);
        for (int i = 0; i < 4; i++) begin
            step(4'b0000);
            chk($sformatf("gap5_a%0d", i), {y5, ev5, b5}, 16'h1);
        end
        step(4'b0111);
        chk("gap5_restart", {y5, ev5, b5}, 16'h1);
        for (int i = 0; i < 5; i++) begin
            step(4'b0000);
            chk($sformatf("gap5_b%0d", i), {y5, ev5, b5}, 16'h1);
        end
        step(4'b1011);
        chk("gap5_exec1", {y5, ev5, c5, o5, b5}, {4'b0010, 1'b1, 2'd1, 2'd3, 1'b1});
        for (int i = 0; i < 5; i++) begin
            step(4'b0000);
            chk($sformatf("gap5_c%0d", i), {y5, ev5, b5}, {4'b0010, 1'b0, 1'b1});
        end
        step(4'b0000);
        chk("gap5_exec2", {y5, ev5, c5, o5, b5}, {4'b0110, 1'b1, 2'd2, 2'd3, 1'b0});
        step(4'b0000);
        chk("gap5_strobe_end", {y5, ev5, c5, o5}, {4'b0110, 1'b0, 2'd2, 2'd3});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
